// File: rtl/mem_ctrl_if.sv
// Requester handshakes (ICache, load/store buffer) plus the byte-wide RAM/IO bus of mem_ctrl.
// The controller connects through 'master'; the surrounding system connects through 'slave'.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic              clear;
    logic              io_buffer_full;

    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [31:0]       ic_ins;
    logic              ic_done;

    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic [31:0]       ls_rdata;
    logic              ls_done;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport master (
        input  rdy, clear, io_buffer_full,
        input  ic_req, ic_addr,
        input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        input  mem_din,
        output ic_ins, ic_done, ls_rdata, ls_done,
        output mem_dout, mem_a, mem_wr
    );

    modport slave (
        output rdy, clear, io_buffer_full,
        output ic_req, ic_addr,
        output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        output mem_din,
        input  ic_ins, ic_done, ls_rdata, ls_done,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: serialises ICache word fetches and LSB byte/half/word accesses into
// single-byte RAM cycles, one request at a time, with exactly one done pulse per request.
module mem_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h30000)
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        LOAD   = 2'd2,
        STORE  = 2'd3
    } state_t;

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] merge_byte(input logic [31:0] w, input logic [1:0] idx,
                                               input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

    state_t            state_r;
    logic [2:0]        cnt_r;
    logic [2:0]        n_r;
    logic [ADDR_W-1:0] base_r;
    logic [31:0]       wdata_r;
    logic [31:0]       acc_r;
    logic [1:0]        a_idx_r;
    logic [1:0]        din_idx_r;
    logic              din_vld_r;

    logic              ls_io_blocked_s;
    logic              ls_ok_s;
    logic              ic_ok_s;
    logic [2:0]        cnt_inc_s;
    logic [ADDR_W-1:0] next_a_s;
    logic [31:0]       acc_next_s;

    // Acceptance decode, next byte address and read-data assembly.
    always_comb begin
        ls_io_blocked_s = bus.ls_we && (bus.ls_addr >= IO_BASE) && bus.io_buffer_full;
        ls_ok_s         = bus.ls_req && !bus.ls_done && !ls_io_blocked_s &&
                          (bus.ls_we || !bus.clear);
        ic_ok_s         = bus.ic_req && !bus.ic_done && !bus.clear;
        cnt_inc_s       = cnt_r + 3'd1;
        next_a_s        = base_r + ADDR_W'(cnt_inc_s);
        if (din_vld_r) begin
            acc_next_s = merge_byte(acc_r, din_idx_r, bus.mem_din);
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Main FSM: arbitration, byte sequencing, registered bus and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 3'd0;
            n_r          <= 3'd0;
            base_r       <= '0;
            wdata_r      <= 32'h0;
            acc_r        <= 32'h0;
            a_idx_r      <= 2'd0;
            din_idx_r    <= 2'd0;
            din_vld_r    <= 1'b0;
            bus.mem_a    <= '0;
            bus.mem_dout <= 8'h00;
            bus.mem_wr   <= 1'b0;
            bus.ic_ins   <= 32'h0;
            bus.ls_rdata <= 32'h0;
            bus.ic_done  <= 1'b0;
            bus.ls_done  <= 1'b0;
        end else begin
            // RAM returns data one cycle after the address, independent of rdy, so the
            // capture pipeline keeps running while the sequencing logic is frozen.
            din_vld_r   <= (state_r == IFETCH) || (state_r == LOAD);
            din_idx_r   <= a_idx_r;
            acc_r       <= acc_next_s;
            bus.ic_done <= 1'b0;
            bus.ls_done <= 1'b0;

            if (!bus.rdy) begin
                bus.mem_wr <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        bus.mem_wr <= 1'b0;
                        cnt_r      <= 3'd0;
                        a_idx_r    <= 2'd0;
                        if (ls_ok_s) begin
                            base_r    <= bus.ls_addr;
                            wdata_r   <= bus.ls_wdata;
                            n_r       <= size_to_n(bus.ls_size);
                            bus.mem_a <= bus.ls_addr;
                            if (bus.ls_we) begin
                                state_r      <= STORE;
                                bus.mem_dout <= bus.ls_wdata[7:0];
                                bus.mem_wr   <= 1'b1;
                            end else begin
                                state_r <= LOAD;
                                acc_r   <= 32'h0;
                            end
                        end else if (ic_ok_s) begin
                            state_r   <= IFETCH;
                            base_r    <= bus.ic_addr;
                            n_r       <= 3'd4;
                            bus.mem_a <= bus.ic_addr;
                            acc_r     <= 32'h0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end

                    IFETCH, LOAD: begin
                        if (bus.clear) begin
                            state_r <= IDLE;
                        end else if (cnt_r == n_r) begin
                            // Last byte arrives on mem_din this cycle; deliver it merged.
                            state_r <= IDLE;
                            if (state_r == IFETCH) begin
                                bus.ic_ins  <= acc_next_s;
                                bus.ic_done <= 1'b1;
                            end else begin
                                bus.ls_rdata <= acc_next_s;
                                bus.ls_done  <= 1'b1;
                            end
                        end else begin
                            cnt_r <= cnt_inc_s;
                            if (cnt_inc_s < n_r) begin
                                bus.mem_a <= next_a_s;
                                a_idx_r   <= cnt_inc_s[1:0];
                            end
                        end
                    end

                    STORE: begin
                        if (cnt_inc_s < n_r) begin
                            cnt_r        <= cnt_inc_s;
                            a_idx_r      <= cnt_inc_s[1:0];
                            bus.mem_a    <= next_a_s;
                            bus.mem_dout <= byte_of(wdata_r, cnt_inc_s[1:0]);
                            bus.mem_wr   <= 1'b1;
                        end else begin
                            bus.mem_wr  <= 1'b0;
                            bus.ls_done <= 1'b1;
                            state_r     <= IDLE;
                        end
                    end

                    default: begin
                        bus.mem_wr <= 1'b0;
                        state_r    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a vector table of single transactions with hand-computed
// data and latency, followed by hand-written multi-cycle corner-case sequences.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .IO_BASE(32'h30000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Byte RAM model (low 16 address bits) plus a log of I/O-space writes.
    logic [7:0]  ram [0:65535];
    logic        pl_we = 1'b0;
    logic [15:0] pl_a  = 16'h0;
    logic [7:0]  pl_d  = 8'h0;
    int          io_wr_cnt = 0;
    logic [31:0] io_addr   = 32'h0;
    logic [7:0]  io_byte   = 8'h0;

    always @(posedge clk) begin
        if (pl_we) begin
            ram[pl_a] <= pl_d;
        end else if (bus.mem_wr) begin
            if (bus.mem_a >= 32'h30000) begin
                io_wr_cnt <= io_wr_cnt + 1;
                io_addr   <= bus.mem_a;
                io_byte   <= bus.mem_dout;
            end else begin
                ram[bus.mem_a[15:0]] <= bus.mem_dout;
            end
        end
        bus.mem_din <= ram[bus.mem_a[15:0]];
    end

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_data;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pl_a  = a;
        pl_d  = d;
        pl_we = 1'b1;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " mem_a"}, bus.mem_a, 32'h0);
        check({tag, " dout/wr/done"}, {21'h0, bus.mem_dout, bus.mem_wr, bus.ic_done, bus.ls_done},
              32'h0);
        check({tag, " ic_ins"}, bus.ic_ins, 32'h0);
        check({tag, " ls_rdata"}, bus.ls_rdata, 32'h0);
    endtask

    // Issue one request in the current cycle (cycle 0) and wait for its done pulse.
    task automatic run_req(input logic is_ls, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] data, output int lat);
        lat  = -1;
        data = 32'h0;
        if (is_ls) begin
            bus.ls_req   = 1'b1;
            bus.ls_we    = we;
            bus.ls_size  = size;
            bus.ls_addr  = addr;
            bus.ls_wdata = wdata;
        end else begin
            bus.ic_req  = 1'b1;
            bus.ic_addr = addr;
        end
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (is_ls ? bus.ls_done : bus.ic_done) begin
                lat  = c;
                data = is_ls ? bus.ls_rdata : bus.ic_ins;
                break;
            end
        end
        bus.ls_req = 1'b0;
        bus.ic_req = 1'b0;
        tick();
    endtask

    logic [31:0] d, d2;
    int          lat, at1, at2, cnt1, cnt2;
    logic [31:0] wv;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         1'b1, 32'h9305_0013, 6};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 32'h0000_2001, 32'h0,         1'b1, 32'h0000_0034, 3};
        vecs[2]  = '{1'b1, 1'b0, 2'd1, 32'h0000_2001, 32'h0,         1'b1, 32'h0000_1234, 4};
        vecs[3]  = '{1'b1, 1'b0, 2'd2, 32'h0000_2001, 32'h0,         1'b1, 32'hA577_1234, 6};
        vecs[4]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0,         5};
        vecs[5]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'h0,         1'b1, 32'hDEAD_BEEF, 6};
        vecs[6]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0080, 32'h1111_CAFE, 1'b0, 32'h0,         3};
        vecs[7]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0080, 32'h0,         1'b1, 32'h0000_CAFE, 6};
        vecs[8]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0100, 32'h0,         1'b1, 32'h9305_0013, 6};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, 32'h0000_0041, 32'h0012_345A, 1'b0, 32'h0,         2};
        vecs[10] = '{1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'h0,         1'b1, 32'hDEAD_5AEF, 6};
        vecs[11] = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0000_5566, 4};
        vecs[12] = '{1'b1, 1'b1, 2'd0, 32'h0003_0004, 32'h0000_0077, 1'b0, 32'h0,         2};

        rst                = 1'b1;
        bus.rdy            = 1'b1;
        bus.clear          = 1'b0;
        bus.io_buffer_full = 1'b0;
        bus.ic_req         = 1'b0;
        bus.ic_addr        = 32'h0;
        bus.ls_req         = 1'b0;
        bus.ls_we          = 1'b0;
        bus.ls_size        = 2'd0;
        bus.ls_addr        = 32'h0;
        bus.ls_wdata       = 32'h0;
        tick();
        poke(16'h0100, 8'h13); poke(16'h0101, 8'h00); poke(16'h0102, 8'h05); poke(16'h0103, 8'h93);
        poke(16'h2001, 8'h34); poke(16'h2002, 8'h12); poke(16'h2003, 8'h77); poke(16'h2004, 8'hA5);
        poke(16'h0082, 8'h00); poke(16'h0083, 8'h00); poke(16'hFFFF, 8'h66); poke(16'h0000, 8'h55);
        check_reset("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_req(vecs[i].is_ls, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, d, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d data", i), d, vecs[i].exp_data);
            end
            check($sformatf("vec%0d single pulse", i), {30'h0, bus.ic_done, bus.ls_done}, 32'h0);
        end
        check("io write count", 32'(io_wr_cnt), 32'd1);
        check("io write byte", {io_addr[23:0], io_byte}, 32'h0300_0477);

        // Fetch trace: addresses in cycles 1-4, one pulse in cycle 6.
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h100;
        cnt1 = 0; at1 = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c <= 4) check($sformatf("fetch mem_a c%0d", c), bus.mem_a, 32'h100 + 32'(c - 1));
            if (bus.mem_wr) cnt1++;
            if (bus.ic_done) begin
                cnt2 = 0;
                at1  = c;
                check("fetch ic_ins", bus.ic_ins, 32'h9305_0013);
            end
            if (bus.ic_done) bus.ic_req = 1'b0;
        end
        bus.ic_req = 1'b0;
        check("fetch done cycle", 32'(at1), 32'd6);
        check("fetch no writes", 32'(cnt1), 32'd0);

        // Simultaneous requests: LSB half-load first, then the fetch.
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd1; bus.ls_addr = 32'h2001;
        bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
        at1 = 0; at2 = 0; d = 32'h0; d2 = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.ls_done) begin at1 = c; d = bus.ls_rdata; bus.ls_req = 1'b0; end
            if (bus.ic_done) begin at2 = c; d2 = bus.ic_ins; bus.ic_req = 1'b0; end
        end
        bus.ls_req = 1'b0; bus.ic_req = 1'b0;
        check("arb ls_done cycle", 32'(at1), 32'd4);
        check("arb ls_rdata", d, 32'h0000_1234);
        check("arb ic_done cycle", 32'(at2), 32'd10);
        check("arb ic_ins", d2, 32'h9305_0013);

        // Store trace: bytes EF,BE,AD,DE to 0x40..0x43 then done in cycle 5.
        wv = 32'hDEAD_BEEF;
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd2;
        bus.ls_addr = 32'h40; bus.ls_wdata = wv;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c <= 4) begin
                check($sformatf("store bus c%0d", c), {bus.mem_wr, 7'h0, bus.mem_dout, bus.mem_a[15:0]},
                      {1'b1, 7'h0, wv[8*(c-1) +: 8], 16'h40 + 16'(c - 1)});
            end else begin
                check("store done cycle", {30'h0, bus.mem_wr, bus.ls_done}, 32'h1);
            end
        end
        bus.ls_req = 1'b0;
        tick();
        check("store ram", {ram[16'h43], ram[16'h42], ram[16'h41], ram[16'h40]}, 32'hDEAD_BEEF);

        // clear in cycle 3 of a fetch aborts it; a load accepted in cycle 4 proves IDLE.
        bus.ic_req = 1'b1; bus.ic_addr = 32'h2001;
        tick(); tick(); tick();
        bus.clear = 1'b1; bus.ic_req = 1'b0;
        tick();
        bus.clear = 1'b0;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd0; bus.ls_addr = 32'h2001;
        cnt1 = 0; at1 = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus.ic_done) cnt1++;
            if (bus.ls_done) begin at1 = c; d = bus.ls_rdata; bus.ls_req = 1'b0; end
        end
        bus.ls_req = 1'b0;
        check("clear no ic_done", 32'(cnt1), 32'd0);
        check("clear ic_ins kept", bus.ic_ins, 32'h9305_0013);
        check("clear then load cycle", 32'(at1), 32'd3);
        check("clear then load data", d, 32'h0000_0034);

        // clear while idle blocks the fetch until it drops.
        bus.clear = 1'b1; bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
        at1 = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 3) bus.clear = 1'b0;
            if (bus.ic_done) begin at1 = c; bus.ic_req = 1'b0; end
        end
        bus.ic_req = 1'b0; bus.clear = 1'b0;
        check("idle clear delays fetch", 32'(at1), 32'd9);

        // clear during a store is ignored.
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd2;
        bus.ls_addr = 32'h60; bus.ls_wdata = 32'h1122_3344;
        at1 = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.clear = (c == 2) || (c == 3);
            if (bus.ls_done) begin at1 = c; bus.ls_req = 1'b0; end
        end
        bus.ls_req = 1'b0; bus.clear = 1'b0;
        check("clear store done cycle", 32'(at1), 32'd5);
        check("clear store ram", {ram[16'h63], ram[16'h62], ram[16'h61], ram[16'h60]}, 32'h1122_3344);

        // I/O store held off by io_buffer_full for 10 cycles.
        bus.io_buffer_full = 1'b1;
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd0;
        bus.ls_addr = 32'h30000; bus.ls_wdata = 32'h41;
        cnt1 = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (bus.mem_wr || bus.ls_done) cnt1++;
        end
        check("io full no write", 32'(cnt1), 32'd0);
        bus.io_buffer_full = 1'b0;
        tick();
        check("io write issued", {bus.mem_wr, 7'h0, bus.mem_dout, bus.mem_a[15:0]}, {1'b1, 7'h0, 8'h41, 16'h0});
        check("io write addr", bus.mem_a, 32'h30000);
        tick();
        check("io ls_done", {31'h0, bus.ls_done}, 32'h1);
        bus.ls_req = 1'b0;
        tick();
        check("io write logged", {io_wr_cnt[7:0], io_addr[23:0]}, {8'd2, 24'h030000});
        check("io byte logged", {24'h0, io_byte}, 32'h41);

        // rdy low for 3 cycles mid-fetch: same word, latency 6 + 3.
        bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
        at1 = 0; cnt1 = 0; d = 32'h0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 5) check("rdy counter held", bus.mem_a, 32'h101);
            if (bus.mem_wr) cnt1++;
            if (bus.ic_done) begin at1 = c; d = bus.ic_ins; bus.ic_req = 1'b0; end
            if (c == 2) bus.rdy = 1'b0;
            if (c == 5) bus.rdy = 1'b1;
        end
        bus.ic_req = 1'b0; bus.rdy = 1'b1;
        check("rdy fetch latency", 32'(at1), 32'd9);
        check("rdy fetch data", d, 32'h9305_0013);
        check("rdy no writes", 32'(cnt1), 32'd0);

        // Reset in the middle of a load: outputs return to reset values, no done.
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd2; bus.ls_addr = 32'h40;
        tick(); tick(); tick();
        rst = 1'b1; bus.ls_req = 1'b0;
        tick();
        rst = 1'b0;
        check_reset("midload rst");
        cnt1 = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (bus.ls_done || bus.ic_done || bus.mem_wr) cnt1++;
        end
        check("midload rst no done", 32'(cnt1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
